// File: rtl/mac_tile_scheduler.sv
// mac_tile_scheduler
//   Walks a tiled matrix job of M x N x K tiles over the MAC4x4 array. For
//   each tile it streams ROWS buffer-load cycles, fires a one-cycle compute
//   start, and then waits for every MAC row to report OVALID. A watchdog
//   aborts a tile that never completes. The job finishes with a job_done
//   pulse, which job_err qualifies.
// Ports
//   CLK, RSTN                  clock (rising edge), async active-low reset
//   job_valid / job_ready      host job handshake (ready iff IDLE)
//   m_tiles/n_tiles/k_tiles    tile counts, sampled on accept
//   abort                      synchronous cancel of the running job
//   mac_OVALID[ROWS]           per-row output-valid from the MAC array
//   LOAD_EN/LOAD_ROW           buffer load strobe and row index
//   A_ADDR/B_ADDR              buffer row addresses (mod 2^ADDR_W)
//   START_CALC/ACC_FIRST/LAST  compute start and accumulate qualifiers
//   tile_m/tile_n/tile_k       current tile indices
//   busy, job_done, job_err    status
module mac_tile_scheduler #(
  parameter int ROWS    = 4,
  parameter int TILE_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64,
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int WD_W   = $clog2(TIMEOUT)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [TILE_W-1:0] m_tiles,
  input  logic [TILE_W-1:0] n_tiles,
  input  logic [TILE_W-1:0] k_tiles,
  input  logic              abort,
  input  logic [ROWS-1:0]   mac_OVALID,
  output logic              LOAD_EN,
  output logic [RW-1:0]     LOAD_ROW,
  output logic [ADDR_W-1:0] A_ADDR,
  output logic [ADDR_W-1:0] B_ADDR,
  output logic              START_CALC,
  output logic              ACC_FIRST,
  output logic              ACC_LAST,
  output logic [TILE_W-1:0] tile_m,
  output logic [TILE_W-1:0] tile_n,
  output logic [TILE_W-1:0] tile_k,
  output logic              busy,
  output logic              job_done,
  output logic              job_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [TILE_W-1:0] m_q, n_q, k_q, m_d, n_d, k_d;
  logic [TILE_W-1:0] mi_q, ni_q, ki_q, mi_d, ni_d, ki_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ROWS-1:0]   mask_q, mask_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic [ROWS-1:0]   mask_now;
  logic              k_wrap, n_wrap, last_tile;
  logic [ADDR_W-1:0] a_addr_c, b_addr_c;

  // Bits arriving this cycle count toward completion.
  assign mask_now  = mask_q | mac_OVALID;
  assign k_wrap    = (ki_q == k_q - TILE_W'(1));
  assign n_wrap    = (ni_q == n_q - TILE_W'(1));
  assign last_tile = k_wrap && n_wrap && (mi_q == m_q - TILE_W'(1));

  // Arithmetic in ADDR_W bits gives the modulo-2^ADDR_W result directly.
  assign a_addr_c = (ADDR_W'(mi_q) * ADDR_W'(k_q) + ADDR_W'(ki_q)) * ADDR_W'(ROWS)
                  + ADDR_W'(row_q);
  assign b_addr_c = (ADDR_W'(ki_q) * ADDR_W'(n_q) + ADDR_W'(ni_q)) * ADDR_W'(ROWS)
                  + ADDR_W'(row_q);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      mi_q    <= '0;
      ni_q    <= '0;
      ki_q    <= '0;
      row_q   <= '0;
      mask_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      k_q     <= k_d;
      mi_q    <= mi_d;
      ni_q    <= ni_d;
      ki_q    <= ki_d;
      row_q   <= row_d;
      mask_q  <= mask_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    k_d     = k_q;
    mi_d    = mi_q;
    ni_d    = ni_q;
    ki_d    = ki_q;
    row_d   = row_q;
    mask_d  = mask_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: if (job_valid) begin
        m_d   = m_tiles;
        n_d   = n_tiles;
        k_d   = k_tiles;
        mi_d  = '0;
        ni_d  = '0;
        ki_d  = '0;
        row_d = '0;
        state_d = (m_tiles == '0 || n_tiles == '0 || k_tiles == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (row_q == RW'(ROWS - 1)) begin
          row_d   = '0;
          state_d = S_START;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      S_START: begin
        mask_d  = '0;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        mask_d = mask_now;
        // Completion is checked first so it wins a tie with the watchdog.
        if (&mask_now)                        state_d = S_NEXT;
        else if (wd_q == WD_W'(TIMEOUT - 1))  state_d = S_ERR;
        else                                  wd_d = wd_q + WD_W'(1);
      end
      S_NEXT: begin
        if (last_tile) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
          if (k_wrap) begin
            ki_d = '0;
            if (n_wrap) begin
              ni_d = '0;
              mi_d = mi_q + TILE_W'(1);
            end else begin
              ni_d = ni_q + TILE_W'(1);
            end
          end else begin
            ki_d = ki_q + TILE_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything while a tile is in flight.
    if (abort && (state_q == S_LOAD || state_q == S_START ||
                  state_q == S_WAIT || state_q == S_NEXT))
      state_d = S_IDLE;
  end

  assign job_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign LOAD_EN    = (state_q == S_LOAD);
  assign LOAD_ROW   = LOAD_EN ? row_q : '0;
  assign A_ADDR     = LOAD_EN ? a_addr_c : '0;
  assign B_ADDR     = LOAD_EN ? b_addr_c : '0;
  assign START_CALC = (state_q == S_START);
  assign ACC_FIRST  = START_CALC && (ki_q == '0);
  assign ACC_LAST   = START_CALC && k_wrap;
  assign tile_m     = mi_q;
  assign tile_n     = ni_q;
  assign tile_k     = ki_q;
  assign job_done   = (state_q == S_DONE) || (state_q == S_ERR);
  assign job_err    = (state_q == S_ERR);

endmodule

// File: tb/tb_mac_tile_scheduler.sv
module tb_mac_tile_scheduler;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        job_valid, job_ready, abort;
  logic [7:0]  m_tiles, n_tiles, k_tiles;
  logic [3:0]  mac_OVALID;
  logic        LOAD_EN, START_CALC, ACC_FIRST, ACC_LAST, busy, job_done, job_err;
  logic [1:0]  LOAD_ROW;
  logic [15:0] A_ADDR, B_ADDR;
  logic [7:0]  tile_m, tile_n, tile_k;

  int errors = 0;
  int checks = 0;

  mac_tile_scheduler #(.ROWS(4), .TILE_W(8), .ADDR_W(16), .TIMEOUT(64)) dut (
    .CLK(CLK), .RSTN(RSTN), .job_valid(job_valid), .job_ready(job_ready),
    .m_tiles(m_tiles), .n_tiles(n_tiles), .k_tiles(k_tiles), .abort(abort),
    .mac_OVALID(mac_OVALID), .LOAD_EN(LOAD_EN), .LOAD_ROW(LOAD_ROW),
    .A_ADDR(A_ADDR), .B_ADDR(B_ADDR), .START_CALC(START_CALC),
    .ACC_FIRST(ACC_FIRST), .ACC_LAST(ACC_LAST), .tile_m(tile_m),
    .tile_n(tile_n), .tile_k(tile_k), .busy(busy), .job_done(job_done),
    .job_err(job_err)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a job and let the accepting edge pass.
  task automatic accept(input logic [7:0] m, input logic [7:0] n, input logic [7:0] k);
    m_tiles = m; n_tiles = n; k_tiles = k; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  // From the first LOAD cycle: 4 loads, start, complete in 1st WAIT cycle.
  task automatic run_tile();
    repeat (4) tick();
    tick();
    mac_OVALID = 4'hF;
    tick();
    mac_OVALID = 4'h0;
    tick();
  endtask

  task automatic test_reset();
    RSTN = 1'b1; job_valid = 1'b0; abort = 1'b0; mac_OVALID = 4'h0;
    m_tiles = 8'd0; n_tiles = 8'd0; k_tiles = 8'd0;
    #3 RSTN = 1'b0;
    tick();
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", job_ready); end
    checks++; if ({busy, LOAD_EN, START_CALC, ACC_FIRST, ACC_LAST, job_done, job_err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {busy, LOAD_EN, START_CALC, ACC_FIRST, ACC_LAST, job_done, job_err}); end
    checks++; if ({LOAD_ROW, A_ADDR, B_ADDR, tile_m, tile_n, tile_k} !== 58'b0) begin
      errors++; $display("FAIL reset_data got %h want 0", {LOAD_ROW, A_ADDR, B_ADDR, tile_m, tile_n, tile_k}); end
    tick();
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_single();
    accept(8'd1, 8'd1, 8'd1);
    for (int r = 0; r < 4; r++) begin
      checks++; if (LOAD_EN !== 1'b1 || LOAD_ROW !== r[1:0]) begin
        errors++; $display("FAIL single_load r=%0d got en=%b row=%0d want en=1 row=%0d", r, LOAD_EN, LOAD_ROW, r); end
      checks++; if (A_ADDR !== r[15:0] || B_ADDR !== r[15:0]) begin
        errors++; $display("FAIL single_addr r=%0d got a=%0d b=%0d want %0d", r, A_ADDR, B_ADDR, r); end
      tick();
    end
    checks++; if ({START_CALC, ACC_FIRST, ACC_LAST, LOAD_EN} !== 4'b1110) begin
      errors++; $display("FAIL single_start got %b want 1110", {START_CALC, ACC_FIRST, ACC_LAST, LOAD_EN}); end
    tick();
    checks++; if (START_CALC !== 1'b0 || busy !== 1'b1 || A_ADDR !== 16'd0) begin
      errors++; $display("FAIL single_wait got start=%b busy=%b a=%0d want 0 1 0", START_CALC, busy, A_ADDR); end
    tick(); tick();
    mac_OVALID = 4'hF;
    tick();
    mac_OVALID = 4'h0;
    checks++; if (job_done !== 1'b0) begin errors++; $display("FAIL single_next got done=%b want 0", job_done); end
    tick();
    checks++; if (job_done !== 1'b1 || job_err !== 1'b0) begin
      errors++; $display("FAIL single_done got done=%b err=%b want 1 0", job_done, job_err); end
    tick();
    checks++; if (job_ready !== 1'b1 || job_done !== 1'b0) begin
      errors++; $display("FAIL single_idle got ready=%b done=%b want 1 0", job_ready, job_done); end
  endtask

  task automatic test_tiled();
    int starts = 0;
    int mi, ni, ki, ea, eb;
    logic bad;
    accept(8'd2, 8'd2, 8'd3);
    for (int t = 0; t < 12; t++) begin
      mi = t / 6; ni = (t / 3) % 2; ki = t % 3;
      bad = 1'b0;
      for (int r = 0; r < 4; r++) begin
        ea = (mi * 3 + ki) * 4 + r;
        eb = (ki * 2 + ni) * 4 + r;
        if (LOAD_EN !== 1'b1 || A_ADDR !== ea[15:0] || B_ADDR !== eb[15:0]) begin
          bad = 1'b1;
          $display("tile %0d row %0d: en=%b a=%0d b=%0d expected a=%0d b=%0d", t, r, LOAD_EN, A_ADDR, B_ADDR, ea, eb);
        end
        if (t == 4) begin
          checks++; if (A_ADDR !== 16'(4 + r) || B_ADDR !== 16'(12 + r)) begin
            errors++; $display("FAIL tiled_t5_addr r=%0d got a=%0d b=%0d want a=%0d b=%0d", r, A_ADDR, B_ADDR, 4 + r, 12 + r); end
        end
        tick();
      end
      checks++; if (bad) begin errors++; $display("FAIL tiled_load tile=%0d got address mismatch want formula", t); end
      if (START_CALC === 1'b1) starts++;
      checks++; if (ACC_FIRST !== (ki == 0) || ACC_LAST !== (ki == 2) ||
                    tile_m !== mi[7:0] || tile_n !== ni[7:0] || tile_k !== ki[7:0]) begin
        errors++; $display("FAIL tiled_start tile=%0d got f=%b l=%b m=%0d n=%0d k=%0d want f=%b l=%b m=%0d n=%0d k=%0d",
                           t, ACC_FIRST, ACC_LAST, tile_m, tile_n, tile_k, ki == 0, ki == 2, mi, ni, ki); end
      tick();
      mac_OVALID = 4'b0001; tick();
      mac_OVALID = 4'b0010; tick();
      mac_OVALID = 4'b0100; tick();
      mac_OVALID = 4'b1000; tick();
      mac_OVALID = 4'b0000;
      if (LOAD_EN !== 1'b0 || busy !== 1'b1 || job_done !== 1'b0) begin
        errors++; checks++; $display("FAIL tiled_next tile=%0d got en=%b busy=%b done=%b want 0 1 0", t, LOAD_EN, busy, job_done);
      end else checks++;
      tick();
    end
    checks++; if (starts !== 12) begin errors++; $display("FAIL tiled_starts got %0d want 12", starts); end
    checks++; if (job_done !== 1'b1 || job_err !== 1'b0) begin
      errors++; $display("FAIL tiled_done got done=%b err=%b want 1 0", job_done, job_err); end
    tick();
  endtask

  task automatic test_zero();
    accept(8'd1, 8'd1, 8'd0);
    checks++; if ({job_done, job_err, busy, LOAD_EN, START_CALC} !== 5'b10100) begin
      errors++; $display("FAIL zero_done got %b want 10100", {job_done, job_err, busy, LOAD_EN, START_CALC}); end
    tick();
    checks++; if ({job_ready, busy, job_done} !== 3'b100) begin
      errors++; $display("FAIL zero_idle got %b want 100", {job_ready, busy, job_done}); end
  endtask

  task automatic test_timeout();
    int early = 0;
    accept(8'd1, 8'd1, 8'd1);
    repeat (4) tick();
    tick();                       // first WAIT cycle
    repeat (63) begin
      tick();
      if (job_done !== 1'b0) early++;
    end
    checks++; if (early != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_early got early=%0d busy=%b want 0 1", early, busy); end
    tick();
    checks++; if (job_done !== 1'b1 || job_err !== 1'b1) begin
      errors++; $display("FAIL timeout_err got done=%b err=%b want 1 1", job_done, job_err); end
    tick();
    checks++; if (job_ready !== 1'b1 || job_done !== 1'b0) begin
      errors++; $display("FAIL timeout_idle got ready=%b done=%b want 1 0", job_ready, job_done); end
  endtask

  task automatic test_abort();
    int dones = 0;
    accept(8'd1, 8'd1, 8'd4);
    run_tile();
    run_tile();
    tick();
    checks++; if (LOAD_EN !== 1'b1 || LOAD_ROW !== 2'd1 || tile_k !== 8'd2) begin
      errors++; $display("FAIL abort_pos got en=%b row=%0d k=%0d want 1 1 2", LOAD_EN, LOAD_ROW, tile_k); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({job_ready, busy, LOAD_EN, job_done} !== 4'b1000) begin
      errors++; $display("FAIL abort_idle got %b want 1000", {job_ready, busy, LOAD_EN, job_done}); end
    repeat (4) begin tick(); if (job_done !== 1'b0) dones++; end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_nodone got %0d want 0", dones); end
    accept(8'd1, 8'd1, 8'd1);
    run_tile();
    checks++; if (job_done !== 1'b1 || job_err !== 1'b0) begin
      errors++; $display("FAIL abort_rerun got done=%b err=%b want 1 0", job_done, job_err); end
    tick();
  endtask

  task automatic test_abort_wait();
    accept(8'd1, 8'd1, 8'd1);
    repeat (4) tick();
    tick();
    mac_OVALID = 4'hF; abort = 1'b1;
    tick();
    mac_OVALID = 4'h0; abort = 1'b0;
    checks++; if (job_ready !== 1'b1 || job_done !== 1'b0) begin
      errors++; $display("FAIL abort_prio got ready=%b done=%b want 1 0", job_ready, job_done); end
    tick();
    checks++; if (job_done !== 1'b0) begin errors++; $display("FAIL abort_prio_after got done=%b want 0", job_done); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    accept(8'd2, 8'd1, 8'd1);
    repeat (4) tick();
    tick(); tick();
    mac_OVALID = 4'hF;
    RSTN = 1'b0;
    #1;
    checks++; if (job_ready !== 1'b1 || {busy, LOAD_EN, START_CALC, ACC_FIRST, ACC_LAST, job_done, job_err} !== 7'b0) begin
      errors++; $display("FAIL rstmid_ctrl got ready=%b ctrl=%b want 1 0", job_ready,
                         {busy, LOAD_EN, START_CALC, ACC_FIRST, ACC_LAST, job_done, job_err}); end
    checks++; if ({LOAD_ROW, A_ADDR, B_ADDR, tile_m, tile_n, tile_k} !== 58'b0) begin
      errors++; $display("FAIL rstmid_data got %h want 0", {LOAD_ROW, A_ADDR, B_ADDR, tile_m, tile_n, tile_k}); end
    tick(); tick();
    RSTN = 1'b1;
    mac_OVALID = 4'h0;
    repeat (5) begin tick(); if (job_done !== 1'b0 || job_ready !== 1'b1) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_after got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tiled();
    test_zero();
    test_timeout();
    test_abort();
    test_abort_wait();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
